// File: rtl/ysyx_22050612_wb_arb_if.sv
// Bus bundle between the execute/load pipelines, decode and the write-back arbiter.
// The slave modport is the arbiter's view. The master modport is the environment's view.
interface ysyx_22050612_wb_arb_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
);
    logic                       exe_valid;
    logic                       exe_ready;
    logic [ADDR_WIDTH-1:0]      exe_rd;
    logic [DATA_WIDTH-1:0]      exe_data;
    logic                       lsu_valid;
    logic                       lsu_ready;
    logic [ADDR_WIDTH-1:0]      lsu_rd;
    logic [DATA_WIDTH-1:0]      lsu_data;
    logic                       iss_valid;
    logic [ADDR_WIDTH-1:0]      iss_rd;
    logic                       rf_wen;
    logic [ADDR_WIDTH-1:0]      rf_waddr;
    logic [DATA_WIDTH-1:0]      rf_wdata;
    logic [(2**ADDR_WIDTH)-1:0] busy;

    modport slave (
        input  exe_valid, exe_rd, exe_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  iss_valid, iss_rd,
        output exe_ready, lsu_ready,
        output rf_wen, rf_waddr, rf_wdata, busy
    );

    modport master (
        output exe_valid, exe_rd, exe_data,
        output lsu_valid, lsu_rd, lsu_data,
        output iss_valid, iss_rd,
        input  exe_ready, lsu_ready,
        input  rf_wen, rf_waddr, rf_wdata, busy
    );
endinterface

// File: rtl/ysyx_22050612_wb_arb.sv
// Write-back arbiter: merges ALU results with FIFO-buffered load results onto the single RF write port.
// It also keeps the outstanding-load busy scoreboard. Define YSYX_22050612_WB_TRACE_EN for a write trace.
module ysyx_22050612_wb_arb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    ysyx_22050612_wb_arb_if.slave wb
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam int NREG  = 2 ** ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] r_fifo_rd   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PTR_W:0]        r_wptr;
    logic [PTR_W:0]        r_rptr;
    logic [CNT_W-1:0]      r_starve;
    logic                  r_wen;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_wb_lsu;
    logic [NREG-1:0]       r_busy;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_lsu_ready;
    logic                  w_push;
    logic                  w_starved;
    logic                  w_grant_exe;
    logic                  w_grant_fifo;
    logic [ADDR_WIDTH-1:0] w_sel_rd;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [CNT_W-1:0]      w_starve_nxt;
    logic [NREG-1:0]       w_set_mask;
    logic [NREG-1:0]       w_clr_mask;
    logic [NREG-1:0]       w_busy_nxt;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign w_empty     = (r_wptr == r_rptr);
    assign w_full      = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                         (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    assign w_lsu_ready = !rst && !w_full;
    assign w_push      = wb.lsu_valid && w_lsu_ready;
    assign w_starved   = (r_starve == CNT_W'(STARVE_MAX));

    // Grant selection: exe by default, FIFO head when exe is idle or the head has starved.
    always_comb begin
        w_grant_fifo = 1'b0;
        w_grant_exe  = 1'b0;
        w_sel_rd     = wb.exe_rd;
        w_sel_data   = wb.exe_data;
        if (rst) begin
            w_grant_fifo = 1'b0;
            w_grant_exe  = 1'b0;
        end else begin
            w_grant_fifo = !w_empty && (!wb.exe_valid || w_starved);
            w_grant_exe  = wb.exe_valid && !w_grant_fifo;
        end
        if (w_grant_fifo) begin
            w_sel_rd   = r_fifo_rd[r_rptr[PTR_W-1:0]];
            w_sel_data = r_fifo_data[r_rptr[PTR_W-1:0]];
        end else begin
            w_sel_rd   = wb.exe_rd;
            w_sel_data = wb.exe_data;
        end
    end

    // Starvation counter next value: counts lost cycles of a waiting head, saturating.
    always_comb begin
        w_starve_nxt = r_starve;
        if (w_empty || w_grant_fifo) begin
            w_starve_nxt = {CNT_W{1'b0}};
        end else if (!w_starved) begin
            w_starve_nxt = r_starve + CNT_W'(1);
        end else begin
            w_starve_nxt = r_starve;
        end
    end

    // Scoreboard next value; set is applied after clear so a same-index issue wins.
    always_comb begin
        w_clr_mask = (r_wen && r_wb_lsu) ? (NREG'(1) << r_waddr) : {NREG{1'b0}};
        w_set_mask = (wb.iss_valid && (wb.iss_rd != {ADDR_WIDTH{1'b0}}))
                   ? (NREG'(1) << wb.iss_rd) : {NREG{1'b0}};
        w_busy_nxt = ((r_busy & ~w_clr_mask) | w_set_mask) & ~NREG'(1);
    end

    // FIFO payload storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wptr[PTR_W-1:0]]   <= wb.lsu_rd;
            r_fifo_data[r_wptr[PTR_W-1:0]] <= wb.lsu_data;
        end
    end

    // FIFO pointers and starvation counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr   <= {(PTR_W+1){1'b0}};
            r_rptr   <= {(PTR_W+1){1'b0}};
            r_starve <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + (PTR_W+1)'(1);
            end
            if (w_grant_fifo) begin
                r_rptr <= r_rptr + (PTR_W+1)'(1);
            end
            r_starve <= w_starve_nxt;
        end
    end

    // Registered RF write port; address/data hold when nothing is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wen    <= 1'b0;
            r_waddr  <= {ADDR_WIDTH{1'b0}};
            r_wdata  <= {DATA_WIDTH{1'b0}};
            r_wb_lsu <= 1'b0;
        end else if (w_grant_exe || w_grant_fifo) begin
            r_wen    <= (w_sel_rd != {ADDR_WIDTH{1'b0}});
            r_waddr  <= w_sel_rd;
            r_wdata  <= w_sel_data;
            r_wb_lsu <= w_grant_fifo;
        end else begin
            r_wen    <= 1'b0;
            r_wb_lsu <= 1'b0;
        end
    end

    // Busy scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= {NREG{1'b0}};
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign wb.exe_ready = w_grant_exe;
    assign wb.lsu_ready = w_lsu_ready;
    assign wb.rf_wen    = r_wen;
    assign wb.rf_waddr  = r_waddr;
    assign wb.rf_wdata  = r_wdata;
    assign wb.busy      = r_busy;

`ifdef YSYX_22050612_WB_TRACE_EN
    // Write trace, simulation only.
    always @(posedge clk) begin
        if (!rst && r_wen) begin
            $display("wb rd=%0d data=%h src=%s", r_waddr, r_wdata, r_wb_lsu ? "lsu" : "exe");
        end
        if (w_grant_fifo && wb.exe_valid) begin
            $display("wb starve");
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_22050612_wb_arb.sv
// Directed self-checking bench for ysyx_22050612_wb_arb.
// Inputs change 1 ns after posedge; all outputs are sampled in the same window.
module tb_ysyx_22050612_wb_arb;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    ysyx_22050612_wb_arb_if #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) bus ();

    ysyx_22050612_wb_arb #(
        .ADDR_WIDTH(5), .DATA_WIDTH(64), .FIFO_DEPTH(4), .STARVE_MAX(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment protocol guard: never issue to, or write from exe into, a busy register.
    always @(posedge clk) begin
        if (!rst && bus.iss_valid && bus.busy[bus.iss_rd]) begin
            $error("protocol: issue to busy rd %0d", bus.iss_rd);
        end
        if (!rst && bus.exe_valid && bus.busy[bus.exe_rd]) begin
            $error("protocol: exe result to busy rd %0d", bus.exe_rd);
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.exe_valid = 1'b0;
        bus.exe_rd    = 5'd0;
        bus.exe_data  = 64'd0;
        bus.lsu_valid = 1'b0;
        bus.lsu_rd    = 5'd0;
        bus.lsu_data  = 64'd0;
        bus.iss_valid = 1'b0;
        bus.iss_rd    = 5'd0;
    endtask

    int k;

    initial begin
        n_checks = 0;
        n_errors = 0;
        k        = 0;
        idle_inputs();

        // Reset with both sources valid.
        rst           = 1'b1;
        bus.exe_valid = 1'b1;
        bus.exe_rd    = 5'd3;
        bus.exe_data  = 64'h11;
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd4;
        bus.lsu_data  = 64'h22;
        tick();
        tick();
        check_val("rst_exe_ready", {63'd0, bus.exe_ready}, 64'd0);
        check_val("rst_lsu_ready", {63'd0, bus.lsu_ready}, 64'd0);
        check_val("rst_rf_wen",    {63'd0, bus.rf_wen}, 64'd0);
        check_val("rst_rf_waddr",  {59'd0, bus.rf_waddr}, 64'd0);
        check_val("rst_rf_wdata",  bus.rf_wdata, 64'd0);
        check_val("rst_busy",      {32'd0, bus.busy}, 64'd0);

        // Release reset: exe granted in the first cycle, written one cycle later.
        rst           = 1'b0;
        bus.lsu_valid = 1'b0;
        #1;
        check_val("post_rst_exe_ready", {63'd0, bus.exe_ready}, 64'd1);
        check_val("post_rst_rf_wen",    {63'd0, bus.rf_wen}, 64'd0);
        tick();
        bus.exe_valid = 1'b0;
        check_val("first_wen",   {63'd0, bus.rf_wen}, 64'd1);
        check_val("first_waddr", {59'd0, bus.rf_waddr}, 64'd3);
        check_val("first_wdata", bus.rf_wdata, 64'h11);
        tick();
        check_val("idle_wen",        {63'd0, bus.rf_wen}, 64'd0);
        check_val("idle_waddr_hold", {59'd0, bus.rf_waddr}, 64'd3);

        // Plain exe write rd=5.
        bus.exe_valid = 1'b1;
        bus.exe_rd    = 5'd5;
        bus.exe_data  = 64'h1234;
        #1;
        check_val("exe5_ready", {63'd0, bus.exe_ready}, 64'd1);
        tick();
        bus.exe_valid = 1'b0;
        check_val("exe5_wen",   {63'd0, bus.rf_wen}, 64'd1);
        check_val("exe5_waddr", {59'd0, bus.rf_waddr}, 64'd5);
        check_val("exe5_wdata", bus.rf_wdata, 64'h1234);
        tick();

        // Issue rd=7, then the load returns with exe idle.
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd7;
        tick();
        bus.iss_valid = 1'b0;
        check_val("busy7_set", {63'd0, bus.busy[7]}, 64'd1);
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd7;
        bus.lsu_data  = 64'hAB;
        #1;
        check_val("ld7_lsu_ready", {63'd0, bus.lsu_ready}, 64'd1);
        tick();
        bus.lsu_valid = 1'b0;
        check_val("ld7_n1_wen",  {63'd0, bus.rf_wen}, 64'd0);
        check_val("ld7_n1_busy", {63'd0, bus.busy[7]}, 64'd1);
        tick();
        check_val("ld7_n2_wen",   {63'd0, bus.rf_wen}, 64'd1);
        check_val("ld7_n2_waddr", {59'd0, bus.rf_waddr}, 64'd7);
        check_val("ld7_n2_wdata", bus.rf_wdata, 64'hAB);
        check_val("ld7_n2_busy",  {63'd0, bus.busy[7]}, 64'd1);
        tick();
        check_val("ld7_n3_busy", {63'd0, bus.busy[7]}, 64'd0);
        check_val("ld7_n3_wen",  {63'd0, bus.rf_wen}, 64'd0);

        // Starvation: exe always valid, one load pushed.
        bus.exe_valid = 1'b1;
        bus.exe_rd    = 5'd1;
        bus.exe_data  = 64'h100;
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd9;
        bus.lsu_data  = 64'h99;
        tick();
        bus.lsu_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_val("starve_exe_wins", {63'd0, bus.exe_ready}, 64'd1);
            tick();
        end
        check_val("starve_forced",     {63'd0, bus.exe_ready}, 64'd0);
        check_val("starve_prev_waddr", {59'd0, bus.rf_waddr}, 64'd1);
        tick();
        check_val("starve_resume", {63'd0, bus.exe_ready}, 64'd1);
        check_val("starve_waddr",  {59'd0, bus.rf_waddr}, 64'd9);
        check_val("starve_wdata",  bus.rf_wdata, 64'h99);
        bus.exe_valid = 1'b0;
        tick();
        tick();

        // Fill the FIFO with exe constantly valid; fifth attempt must be refused.
        bus.exe_valid = 1'b1;
        bus.exe_rd    = 5'd2;
        bus.exe_data  = 64'h200;
        bus.lsu_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.lsu_rd   = 5'(10 + i);
            bus.lsu_data = 64'hA0 + 64'(i);
            #1;
            check_val("fill_lsu_ready", {63'd0, bus.lsu_ready}, 64'd1);
            tick();
        end
        bus.lsu_rd   = 5'd14;
        bus.lsu_data = 64'hA4;
        #1;
        check_val("full_lsu_ready", {63'd0, bus.lsu_ready}, 64'd0);
        check_val("full_forced",    {63'd0, bus.exe_ready}, 64'd0);
        tick();
        bus.lsu_valid = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (bus.rf_wen && bus.rf_waddr >= 5'd10) begin
                check_val("drain_waddr", {59'd0, bus.rf_waddr}, 64'd10 + 64'(k));
                check_val("drain_wdata", bus.rf_wdata, 64'hA0 + 64'(k));
                k = k + 1;
            end
            tick();
        end
        check_val("drain_count", 64'(k), 64'd4);
        bus.exe_valid = 1'b0;
        tick();

        // x0 results and x0 issue.
        bus.exe_valid = 1'b1;
        bus.exe_rd    = 5'd0;
        bus.exe_data  = 64'hFFFF;
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd0;
        bus.lsu_data  = 64'h55;
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd0;
        #1;
        check_val("x0_exe_ready", {63'd0, bus.exe_ready}, 64'd1);
        check_val("x0_lsu_ready", {63'd0, bus.lsu_ready}, 64'd1);
        tick();
        idle_inputs();
        check_val("x0_exe_wen",   {63'd0, bus.rf_wen}, 64'd0);
        check_val("x0_exe_wdata", bus.rf_wdata, 64'hFFFF);
        check_val("x0_busy",      {32'd0, bus.busy}, 64'd0);
        tick();
        check_val("x0_lsu_wen",   {63'd0, bus.rf_wen}, 64'd0);
        check_val("x0_lsu_wdata", bus.rf_wdata, 64'h55);
        tick();

        // Reset mid-operation discards busy bits and the queued load.
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd20;
        tick();
        bus.iss_valid = 1'b0;
        bus.exe_valid = 1'b1;
        bus.exe_rd    = 5'd2;
        bus.exe_data  = 64'h300;
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd20;
        bus.lsu_data  = 64'hC0;
        tick();
        bus.lsu_valid = 1'b0;
        check_val("mid_busy20", {63'd0, bus.busy[20]}, 64'd1);
        rst = 1'b1;
        #1;
        check_val("mid_rst_busy",      {32'd0, bus.busy}, 64'd0);
        check_val("mid_rst_wen",       {63'd0, bus.rf_wen}, 64'd0);
        check_val("mid_rst_exe_ready", {63'd0, bus.exe_ready}, 64'd0);
        tick();
        rst           = 1'b0;
        bus.exe_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_val("after_rst_no_write", {63'd0, bus.rf_wen}, 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
